// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a single-outstanding
// instruction-memory port, with stall absorption (one-entry skid) and redirect flushing.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] npc_aligned;

  assign npc_aligned = npc_i & ALIGN_MASK;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC & ALIGN_MASK;
      redir_pc_q   <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_instr_q  <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Redirect outranks stall everywhere; a flush leaves if_id_pc untouched.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    imem_req_o   = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end

      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            pc_d         = npc_aligned;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end else if (stall_i) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata_i;
            state_d     = HOLD;
          end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata_i;
            ifid_valid_d = 1'b1;
            pc_d         = npc_aligned;
          end
        end else if (redirect_i) begin
          redir_pc_d   = npc_aligned;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          state_d      = KILL;
        end else if (!stall_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end

      // The wrong-path request is still in flight; swallow its response before refetching.
      KILL: begin
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
        if (imem_rvalid_i) begin
          pc_d    = redirect_i ? npc_aligned : redir_pc_q;
          state_d = FETCH;
        end else if (redirect_i) begin
          redir_pc_d = npc_aligned;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d         = npc_aligned;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          state_d      = FETCH;
        end else if (!stall_i) begin
          ifid_pc_d    = buf_pc_q;
          ifid_instr_d = buf_instr_q;
          ifid_valid_d = 1'b1;
          pc_d         = npc_aligned;
          state_d      = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_instr_o = ifid_instr_q;
  assign if_id_valid_o = ifid_valid_q;

endmodule
